// File: rtl/eaglesong_sponge_ctrl.sv
// Eaglesong sponge controller: absorbs 32-bit message words, drives an external permutation engine, squeezes 8 digest words.
// Define EAGLESONG_SPONGE_PAD_EN to enable in-core byte padding (PAD state, in_bytes masking); otherwise blocks arrive pre-padded.
module eaglesong_sponge_ctrl (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_word,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_bytes,
  output logic [15:0][31:0] perm_state_input,
  output logic              perm_start_eval,
  input  logic [15:0][31:0] perm_state_output,
  input  logic              perm_eval_output_ready,
  output logic [31:0]       out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 3;
  localparam logic [WORD_W-1:0] PAD_WORD = 32'h0600_0000;

  typedef enum logic [2:0] {
    S_ABSORB,
    S_PERM_START,
    S_PERM_WAIT,
`ifdef EAGLESONG_SPONGE_PAD_EN
    S_PAD,
`endif
    S_SQUEEZE
  } state_e;

  state_e                fsm_q, fsm_d;
  logic [15:0][WORD_W-1:0] st_q, st_d;
  logic [IDX_W-1:0]      widx_q, widx_d;
  logic [IDX_W-1:0]      oidx_q, oidx_d;
  logic                  final_q, final_d;
  logic                  in_ready_q, busy_q, perm_start_q, out_valid_q;
  logic [WORD_W-1:0]     out_word_q;
  logic [3:0]            widx_ix;
  logic                  accept;

  assign widx_ix = {1'b0, widx_q};
  assign accept  = in_valid && in_ready_q;

`ifdef EAGLESONG_SPONGE_PAD_EN
  logic       pad_pend_q, pad_pend_d;
  logic [2:0] in_nbytes;

  assign in_nbytes = (in_bytes > 3'd4) ? 3'd4 : in_bytes;

  // Partial final word: keep the valid leading bytes and place the 0x06 pad byte right after them.
  function automatic logic [WORD_W-1:0] pad_partial(input logic [WORD_W-1:0] w, input logic [2:0] nb);
    case (nb)
      3'd0:    pad_partial = PAD_WORD;
      3'd1:    pad_partial = {w[31:24], 24'h06_0000};
      3'd2:    pad_partial = {w[31:16], 16'h0600};
      3'd3:    pad_partial = {w[31:8], 8'h06};
      default: pad_partial = w;
    endcase
  endfunction
`else
  logic unused_in_bytes;
  assign unused_in_bytes = ^in_bytes;
`endif

  always_comb begin
    fsm_d   = fsm_q;
    st_d    = st_q;
    widx_d  = widx_q;
    oidx_d  = oidx_q;
    final_d = final_q;
`ifdef EAGLESONG_SPONGE_PAD_EN
    pad_pend_d = pad_pend_q;
`endif
    case (fsm_q)
      S_ABSORB: begin
        if (accept) begin
`ifdef EAGLESONG_SPONGE_PAD_EN
          if (in_last && (in_nbytes != 3'd4)) begin
            st_d[widx_ix] = st_q[widx_ix] ^ pad_partial(in_word, in_nbytes);
            final_d       = 1'b1;
            fsm_d         = S_PERM_START;
          end else begin
            st_d[widx_ix] = st_q[widx_ix] ^ in_word;
            widx_d        = widx_q + 3'd1;
            // Full final word: pad goes into the next rate word, or into word 0 of a fresh block.
            if (in_last && (widx_q == 3'd7)) begin
              pad_pend_d = 1'b1;
              fsm_d      = S_PERM_START;
            end else if (in_last) begin
              fsm_d = S_PAD;
            end else if (widx_q == 3'd7) begin
              fsm_d = S_PERM_START;
            end
          end
`else
          st_d[widx_ix] = st_q[widx_ix] ^ in_word;
          widx_d        = widx_q + 3'd1;
          if (widx_q == 3'd7) begin
            final_d = in_last;
            fsm_d   = S_PERM_START;
          end
`endif
        end
      end
`ifdef EAGLESONG_SPONGE_PAD_EN
      S_PAD: begin
        st_d[widx_ix] = st_q[widx_ix] ^ PAD_WORD;
        final_d       = 1'b1;
        pad_pend_d    = 1'b0;
        fsm_d         = S_PERM_START;
      end
`endif
      S_PERM_START: fsm_d = S_PERM_WAIT;
      S_PERM_WAIT: begin
        if (perm_eval_output_ready) begin
          st_d = perm_state_output;
`ifdef EAGLESONG_SPONGE_PAD_EN
          if (pad_pend_q) begin
            fsm_d = S_PAD;
          end else
`endif
          if (final_q) begin
            oidx_d = '0;
            fsm_d  = S_SQUEEZE;
          end else begin
            fsm_d = S_ABSORB;
          end
        end
      end
      S_SQUEEZE: begin
        if (out_valid_q && out_ready) begin
          oidx_d = oidx_q + 3'd1;
          if (oidx_q == 3'd7) begin
            st_d    = '0;
            widx_d  = '0;
            final_d = 1'b0;
            fsm_d   = S_ABSORB;
          end
        end
      end
      default: fsm_d = S_ABSORB;
    endcase
  end

  // Outputs are registered from the next state so they always match the current state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= S_ABSORB;
      st_q         <= '0;
      widx_q       <= '0;
      oidx_q       <= '0;
      final_q      <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      perm_start_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
`ifdef EAGLESONG_SPONGE_PAD_EN
      pad_pend_q   <= 1'b0;
`endif
    end else begin
      fsm_q        <= fsm_d;
      st_q         <= st_d;
      widx_q       <= widx_d;
      oidx_q       <= oidx_d;
      final_q      <= final_d;
      in_ready_q   <= (fsm_d == S_ABSORB);
      busy_q       <= (fsm_d != S_ABSORB);
      perm_start_q <= (fsm_d == S_PERM_START);
      out_valid_q  <= (fsm_d == S_SQUEEZE);
      out_word_q   <= st_d[{1'b0, oidx_d}];
`ifdef EAGLESONG_SPONGE_PAD_EN
      pad_pend_q   <= pad_pend_d;
`endif
    end
  end

  assign in_ready         = in_ready_q;
  assign busy             = busy_q;
  assign perm_start_eval  = perm_start_q;
  assign perm_state_input = st_q;
  assign out_valid        = out_valid_q;
  assign out_word         = out_word_q;

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// Randomized bench for eaglesong_sponge_ctrl: a behavioural permutation engine plus a byte-level sponge reference model.
// Honours EAGLESONG_SPONGE_PAD_EN the same way as the design.
module tb_eaglesong_sponge_ctrl;

  typedef logic [15:0][31:0] st_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_word;
  logic        in_valid, in_ready, in_last;
  logic [2:0]  in_bytes;
  st_t         perm_state_input, perm_state_output;
  logic        perm_start_eval, perm_eval_output_ready;
  logic [31:0] out_word;
  logic        out_valid, out_ready, busy;

  always #5 clk = ~clk;

  eaglesong_sponge_ctrl dut (
    .clk(clk), .reset(reset),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_bytes(in_bytes),
    .perm_state_input(perm_state_input), .perm_start_eval(perm_start_eval),
    .perm_state_output(perm_state_output), .perm_eval_output_ready(perm_eval_output_ready),
    .out_word(out_word), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Stand-in permutation shared by the engine model and the reference model.
  function automatic st_t perm_f(input st_t s);
    st_t r;
    for (int i = 0; i < 16; i++)
      r[4'(i)] = (s[4'(i)] ^ rotl(s[4'(i + 1)], i + 1)) + (s[4'(i + 5)] * 32'h9E37_79B1) ^ 32'(i);
    return r;
  endfunction

  // Engine: latches state on the start strobe, answers after 2..5 cycles, keeps ready high afterwards.
  st_t eng_log[$];
  st_t eng_in;
  bit  eng_busy;
  int  eng_cnt;
  initial begin
    perm_eval_output_ready = 1'b0;
    perm_state_output      = '0;
    eng_busy = 1'b0;
    eng_cnt  = 0;
    forever begin
      @(negedge clk);
      if (eng_busy) begin
        if (eng_cnt == 0) begin
          perm_state_output      = perm_f(eng_in);
          perm_eval_output_ready = 1'b1;
          eng_busy               = 1'b0;
        end else eng_cnt--;
      end
      if (perm_start_eval) begin
        eng_in = perm_state_input;
        eng_log.push_back(perm_state_input);
        perm_eval_output_ready = 1'b0;
        eng_busy = 1'b1;
        eng_cnt  = $urandom_range(2, 5);
      end
    end
  end

  logic [7:0]  mb[$];
  logic [31:0] pw[$];
  logic [31:0] dw[$];
  bit          dl[$];
  logic [2:0]  db[$];
  st_t         exp_eng[$];
  logic [31:0] exp_dig[8];
  bit          garb_ff;

  function automatic logic [31:0] eng_word(input int idx, input int k);
    if (idx < eng_log.size()) return eng_log[idx][4'(k)];
    return 32'hDEAD_BEEF;
  endfunction

  // Reference sponge over the padded word stream: XOR each 8-word block into the rate, permute, digest = rate.
  task automatic model_words();
    st_t s;
    s = '0;
    exp_eng.delete();
    for (int blk = 0; blk < pw.size() / 8; blk++) begin
      for (int j = 0; j < 8; j++) s[4'(j)] = s[4'(j)] ^ pw[8 * blk + j];
      exp_eng.push_back(s);
      s = perm_f(s);
    end
    for (int j = 0; j < 8; j++) exp_dig[j] = s[4'(j)];
  endtask

  // Padded message: bytes, then 0x06, then zeros up to a 32-byte block boundary.
  task automatic build_pad();
    int n, nw, b, idx;
    logic [31:0] w;
    logic [7:0]  pb[$];
    n = mb.size();
    dw.delete(); dl.delete(); db.delete(); pw.delete();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * k + j;
        w = {w[23:0], (idx < n) ? mb[idx] : (garb_ff ? 8'hFF : 8'($urandom))};
      end
      dw.push_back(w);
      dl.push_back(k == nw - 1);
      b = n - 4 * k;
      if (k != nw - 1) db.push_back(3'($urandom));
      else if (b == 4) db.push_back(3'(4 + $urandom_range(0, 3)));
      else db.push_back(3'(b));
    end
    pb = mb;
    pb.push_back(8'h06);
    while (pb.size() % 32 != 0) pb.push_back(8'h00);
    for (int k = 0; k < pb.size() / 4; k++)
      pw.push_back({pb[4 * k], pb[4 * k + 1], pb[4 * k + 2], pb[4 * k + 3]});
    model_words();
  endtask

  // Pre-padded blocks; stray in_last away from word 7 must be ignored.
  task automatic build_np(input int nblk);
    logic [31:0] w;
    dw.delete(); dl.delete(); db.delete(); pw.delete();
    for (int i = 0; i < nblk * 8; i++) begin
      w = $urandom;
      pw.push_back(w);
      dw.push_back(w);
      dl.push_back((i == nblk * 8 - 1) || ((i % 8 != 7) && ($urandom_range(0, 3) == 0)));
      db.push_back(3'($urandom));
    end
    model_words();
  endtask

  task automatic send_word(input logic [31:0] w, input bit last, input logic [2:0] nb);
    int cyc;
    in_word = w; in_last = last; in_bytes = nb; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) chk("in_ready_timeout", 32'(cyc), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_msg(input string nm, input bit stall10);
    int base, got, cyc;
    logic [31:0] digs[8];
    base = eng_log.size();
    for (int k = 0; k < dw.size(); k++) send_word(dw[k], dl[k], db[k]);
    for (int j = 0; j < 8; j++) digs[j] = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    if (stall10) begin
      cyc = 0;
      while (!out_valid && cyc < 500) begin
        @(negedge clk);
        cyc++;
      end
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk({nm, "_stall_word"}, out_word, exp_dig[0]);
        chk({nm, "_stall_valid"}, 32'(out_valid), 32'd1);
      end
    end
    got = 0;
    cyc = 0;
    while (got < 8 && cyc < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (out_valid && out_ready) begin
        digs[got] = out_word;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    chk({nm, "_ndigest"}, 32'(got), 32'd8);
    chk({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_idle_ovalid"}, 32'(out_valid), 32'd0);
    for (int j = 0; j < 8; j++) chk($sformatf("%s_dig%0d", nm, j), digs[j], exp_dig[j]);
    chk({nm, "_nperm"}, 32'(eng_log.size() - base), 32'(exp_eng.size()));
    for (int i = 0; i < exp_eng.size(); i++)
      for (int k = 0; k < 16; k++)
        chk($sformatf("%s_eng%0d_w%0d", nm, i, k), eng_word(base + i, k), exp_eng[i][4'(k)]);
  endtask

  // Abort a message while the engine is still computing, then run a fresh one.
  task automatic reset_mid_perm();
    int s0, cyc;
    s0 = eng_log.size();
    for (int k = 0; k < 8; k++) send_word($urandom, 1'b0, 3'($urandom));
    cyc = 0;
    while (eng_log.size() == s0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_first_start", 32'(eng_log.size() - s0), 32'd1);
    @(negedge clk);
    chk("rst_in_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = eng_log.size();
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state0", perm_state_input[0], 32'd0);
    repeat (10) @(negedge clk);
    chk("rst_no_start", 32'(eng_log.size() - s0), 32'd0);
    chk("rst_still_idle", 32'(busy), 32'd0);
`ifdef EAGLESONG_SPONGE_PAD_EN
    mb.delete();
    mb.push_back(8'($urandom));
    mb.push_back(8'($urandom));
    garb_ff = 1'b0;
    build_pad();
`else
    build_np(1);
`endif
    run_msg("after_rst", 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, n;
    reset = 1'b1; in_valid = 1'b0; in_word = '0; in_last = 1'b0; in_bytes = '0; out_ready = 1'b0;
    garb_ff = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_start", 32'(perm_start_eval), 32'd0);
    for (int k = 0; k < 16; k++) chk($sformatf("reset_st%0d", k), perm_state_input[4'(k)], 32'd0);

`ifdef EAGLESONG_SPONGE_PAD_EN
    mb.delete();
    garb_ff = 1'b1;
    build_pad();
    b0 = eng_log.size();
    run_msg("empty", 1'b0);
    chk("empty_w0", eng_word(b0, 0), 32'h0600_0000);
    chk("empty_w1", eng_word(b0, 1), 32'd0);
    chk("empty_w15", eng_word(b0, 15), 32'd0);

    mb = '{8'h61, 8'h62, 8'h63};
    build_pad();
    chk("abc_drive", dw[0], 32'h6162_63FF);
    b0 = eng_log.size();
    run_msg("abc", 1'b0);
    chk("abc_w0", eng_word(b0, 0), 32'h6162_6306);

    garb_ff = 1'b0;
    mb.delete();
    for (int i = 0; i < 32; i++) mb.push_back(8'($urandom));
    build_pad();
    db[db.size() - 1] = 3'd4;
    b0 = eng_log.size();
    run_msg("m32", 1'b0);
    chk("m32_nperm", 32'(eng_log.size() - b0), 32'd2);

    mb.delete();
    for (int i = 0; i < 10; i++) mb.push_back(8'($urandom));
    build_pad();
    run_msg("stall", 1'b1);

    for (int t = 0; t < 14; t++) begin
      n = (t < 4) ? 28 + t : $urandom_range(0, 70);
      mb.delete();
      for (int i = 0; i < n; i++) mb.push_back(8'($urandom));
      build_pad();
      run_msg($sformatf("rnd%0d_len%0d", t, n), 1'b0);
    end
`else
    build_np(1);
    b0 = eng_log.size();
    run_msg("oneblk", 1'b0);
    chk("oneblk_nperm", 32'(eng_log.size() - b0), 32'd1);

    build_np(2);
    run_msg("stall", 1'b1);

    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 3);
      build_np(n);
      run_msg($sformatf("rnd%0d_blk%0d", t, n), 1'b0);
    end
`endif

    reset_mid_perm();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
